// File: rtl/joypad_uart_pkg.sv
// Shared constants and state types for the serial-fed NES controller port block.
package joypad_uart_pkg;

  // Button bit positions inside a pad byte (1 = pressed)
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Frame headers sent by the host ahead of a button byte
  localparam logic [7:0] HDR_PAD1 = 8'hF0;
  localparam logic [7:0] HDR_PAD2 = 8'hF1;

  // CPU-visible controller registers
  localparam logic [15:0] ADDR_JOY1 = 16'h4016;
  localparam logic [15:0] ADDR_JOY2 = 16'h4017;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic       {P_IDLE, P_DATA} parse_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial receiver: synchronises rx, samples mid-bit, flags stop-bit errors.
module uart_rx_byte
  import joypad_uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] MID  = CW'(DIV / 2 - 1);

  uart_state_t   st, st_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    sh, sh_nx;
  logic          valid_nx, err_nx;
  logic          rx_m, rx_s, rx_d;

  assign data = sh;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // Receiver state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= U_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      st      <= st_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      sh      <= sh_nx;
      valid   <= valid_nx;
      err     <= err_nx;
    end
  end

  // Bit timing: half a bit to reach the start-bit centre, then one bit per sample
  always_comb begin
    st_nx    = st;
    cnt_nx   = cnt + 1'b1;
    bit_nx   = bit_idx;
    sh_nx    = sh;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (st)
      U_IDLE: begin
        cnt_nx = '0;
        if (rx_d && !rx_s) st_nx = U_START;
      end
      U_START: begin
        if (cnt == MID) begin
          cnt_nx = '0;
          bit_nx = '0;
          st_nx  = rx_s ? U_IDLE : U_DATA;  // glitch, not a real start bit
        end
      end
      U_DATA: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          sh_nx  = {rx_s, sh[7:1]};  // LSB arrives first
          bit_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) st_nx = U_STOP;
        end
      end
      U_STOP: begin
        if (cnt == LAST) begin
          cnt_nx = '0;
          st_nx  = U_IDLE;
          if (rx_s) valid_nx = 1'b1;
          else      err_nx   = 1'b1;
        end
      end
      default: st_nx = U_IDLE;
    endcase
  end

endmodule

// File: rtl/joypad_uart.sv
// NES $4016/$4017 responder whose button state arrives as F0/F1-prefixed serial frames.
module joypad_uart
  import joypad_uart_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  din,
  input  logic        we,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        hit,
  input  logic        rx,
  output logic        frame_ok,
  output logic        rx_err
);

  logic [7:0]   byte_data;
  logic         byte_valid, byte_err;
  parse_state_t p_st, p_nx;
  logic         pad_sel, pad_sel_nx, commit;
  logic [7:0]   btn1, btn2, sh1, sh2;
  logic         strobe, rd_q;
  logic [15:0]  addr_q;
  logic         sel_j1, sel_j2, rd_edge, wr_strobe;
  logic         unused_din;

  uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .data  (byte_data),
    .valid (byte_valid),
    .err   (byte_err)
  );

  assign rx_err     = byte_err;
  assign unused_din = ^din[7:1];

  assign sel_j1    = (address == ADDR_JOY1);
  assign sel_j2    = (address == ADDR_JOY2);
  assign hit       = sel_j1 | sel_j2;
  // A held rd on the same register counts only once
  assign rd_edge   = rd & hit & ~(rd_q & (addr_q == address));
  assign wr_strobe = we & sel_j1;

  // Open-bus high bits read back as $40; bit 0 is the current serial button
  always_comb begin
    dout = 8'h00;
    if (sel_j1)      dout = {7'b0100000, sh1[0]};
    else if (sel_j2) dout = {7'b0100000, sh2[0]};
  end

  // Frame parser: header picks the pad, the following byte is its button state
  always_comb begin
    p_nx       = p_st;
    pad_sel_nx = pad_sel;
    commit     = 1'b0;
    if (byte_err) begin
      p_nx = P_IDLE;  // a broken byte also discards any pending header
    end else if (byte_valid) begin
      case (p_st)
        P_IDLE: begin
          if (byte_data == HDR_PAD1) begin
            p_nx       = P_DATA;
            pad_sel_nx = 1'b0;
          end else if (byte_data == HDR_PAD2) begin
            p_nx       = P_DATA;
            pad_sel_nx = 1'b1;
          end
        end
        P_DATA: begin
          commit = 1'b1;
          p_nx   = P_IDLE;
        end
        default: p_nx = P_IDLE;
      endcase
    end
  end

  // Parser state and committed button latches
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p_st     <= P_IDLE;
      pad_sel  <= 1'b0;
      btn1     <= 8'h00;
      btn2     <= 8'h00;
      frame_ok <= 1'b0;
    end else begin
      p_st     <= p_nx;
      pad_sel  <= pad_sel_nx;
      frame_ok <= commit;
      if (commit) begin
        if (pad_sel) btn2 <= byte_data;
        else         btn1 <= byte_data;
      end
    end
  end

  // Strobe register, read-edge history and the two CPU-facing shifters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 16'h0000;
      sh1    <= 8'h00;
      sh2    <= 8'h00;
    end else begin
      rd_q   <= rd;
      addr_q <= address;
      if (wr_strobe) strobe <= din[0];
      if (strobe) begin
        sh1 <= btn1;
        sh2 <= btn2;
      end else if (rd_edge && !wr_strobe) begin
        // Shift in ones so an exhausted pad reads $41 forever
        if (sel_j1) sh1 <= {1'b1, sh1[7:1]};
        else        sh2 <= {1'b1, sh2[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_joypad_uart.sv
// Randomised scoreboard bench for joypad_uart with a byte/frame-level reference model.
`timescale 1ns/1ps
module tb_joypad_uart;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = CLK_HZ / BAUD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic        we = 1'b0, rd = 1'b0, rx = 1'b1;
  logic [7:0]  dout;
  logic        hit, frame_ok, rx_err;

  joypad_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clock(clock), .reset(reset), .address(address), .din(din), .we(we), .rd(rd),
    .dout(dout), .hit(hit), .rx(rx), .frame_ok(frame_ok), .rx_err(rx_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        hit;
  } rd_exp_t;

  rd_exp_t exp_rd[$];
  int      exp_ev[$];   // 1 = frame_ok, 2 = rx_err
  int      tests = 0, fails = 0;
  logic    rd_chk = 1'b0;

  // Reference model: committed buttons, snapshot taken at strobe release, read index
  logic [7:0] m_btn[2];
  logic [7:0] m_lat[2];
  int         m_idx[2];
  bit         m_strobe, m_pend;
  int         m_pad;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_btn[p] = 8'h00; m_lat[p] = 8'h00; m_idx[p] = 0;
    end
    m_strobe = 0; m_pend = 0; m_pad = 0;
  endtask

  function automatic logic model_bit(input int p);
    if (m_strobe)    return m_btn[p][0];
    if (m_idx[p] < 8) return m_lat[p][m_idx[p]];
    return 1'b1;
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit bad);
    if (bad) begin
      m_pend = 0;
      exp_ev.push_back(2);
    end else if (m_pend) begin
      m_btn[m_pad] = b;
      m_pend = 0;
      exp_ev.push_back(1);
    end else if (b == 8'hF0) begin
      m_pend = 1; m_pad = 0;
    end else if (b == 8'hF1) begin
      m_pend = 1; m_pad = 1;
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] v);
    if (a == 16'h4016) begin
      if (m_strobe && !v[0]) begin
        m_lat = m_btn;
        m_idx[0] = 0; m_idx[1] = 0;
      end
      m_strobe = v[0];
    end
  endtask

  function automatic rd_exp_t model_read(input logic [15:0] a, input bit shift);
    rd_exp_t e;
    int p;
    e.addr = a;
    e.hit  = (a == 16'h4016) || (a == 16'h4017);
    e.dout = 8'h00;
    if (e.hit) begin
      p = (a == 16'h4017) ? 1 : 0;
      e.dout = {7'b0100000, model_bit(p)};
      if (shift && !m_strobe) m_idx[p]++;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (DIV) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad = 0);
    model_byte(b, bad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(!bad);
    rx = 1'b1;
    repeat (8) tick();
  endtask

  task automatic do_read(input logic [15:0] a, input int hold = 1);
    exp_rd.push_back(model_read(a, 1));
    address = a; rd = 1'b1; rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
    repeat (hold - 1) tick();
    rd = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] v);
    model_write(a, v);
    address = a; din = v; we = 1'b1;
    tick();
    we = 1'b0;
    tick();
  endtask

  // Write and read-edge to $4016 in the same cycle: value read, no shift
  task automatic do_write_read(input logic [7:0] v);
    exp_rd.push_back(model_read(16'h4016, 0));
    model_write(16'h4016, v);
    address = 16'h4016; din = v; we = 1'b1; rd = 1'b1; rd_chk = 1'b1;
    tick();
    we = 1'b0; rd = 1'b0; rd_chk = 1'b0;
    tick();
  endtask

  task automatic strobe_pulse();
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
  endtask

  // Monitor: compare reads and pulses as the DUT presents them
  always @(negedge clock) begin
    rd_exp_t e;
    int ev;
    if (rd_chk) begin
      tests++;
      if (exp_rd.size() == 0) begin
        fails++;
        $display("FAIL read_underflow: dout=%h with no expectation queued", dout);
      end else begin
        e = exp_rd.pop_front();
        if (dout !== e.dout || hit !== e.hit) begin
          fails++;
          $display("FAIL read %h: got dout=%h hit=%b, expected dout=%h hit=%b",
                   e.addr, dout, hit, e.dout, e.hit);
        end
      end
    end
    if (!reset && (frame_ok || rx_err)) begin
      tests++;
      ev = frame_ok ? (rx_err ? 3 : 1) : 2;
      if (exp_ev.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got event %0d, expected none", ev);
      end else if (exp_ev[0] != ev) begin
        fails++;
        $display("FAIL pulse: got event %0d, expected %0d", ev, exp_ev[0]);
        void'(exp_ev.pop_front());
      end else begin
        void'(exp_ev.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state and address decode
    do_read(16'h4016);
    do_read(16'h4000);
    do_read(16'h4017);

    // Pad 1 = A + Right, nine reads through exhaustion
    send_byte(8'hF0); send_byte(8'h81);
    strobe_pulse();
    for (int i = 0; i < 9; i++) do_read(16'h4016);

    // Pad 2 = B
    send_byte(8'hF1); send_byte(8'h02);
    strobe_pulse();
    do_read(16'h4017); do_read(16'h4017);
    do_read(16'h4016);

    // Framing error on the header drops it; the following byte is ignored
    send_byte(8'hF0, 1);
    send_byte(8'h55);
    strobe_pulse();
    do_read(16'h4016); do_read(16'h4016);
    send_byte(8'hF0); send_byte(8'h01);
    strobe_pulse();
    do_read(16'h4016); do_read(16'h4016);

    // Strobe held high while a frame lands: reads follow A and never shift
    do_write(16'h4016, 8'h01);
    send_byte(8'hF0); send_byte(8'h00);
    do_read(16'h4016);
    send_byte(8'hF0); send_byte(8'h01);
    for (int i = 0; i < 3; i++) do_read(16'h4016);
    do_write(16'h4016, 8'h00);

    // $4017 write ignored; write beats a simultaneous read
    do_write(16'h4017, 8'h01);
    do_read(16'h4016);
    do_write_read(8'h00);
    do_read(16'h4016);

    // Held rd shifts once
    strobe_pulse();
    do_read(16'h4016, 5);
    do_read(16'h4016);

    // Reset in the middle of a byte, then a clean full frame
    rx = 1'b0;
    repeat (DIV * 3) tick();
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    tick();
    do_read(16'h4016);
    send_byte(8'hF0); send_byte(8'hFF);
    strobe_pulse();
    for (int i = 0; i < 9; i++) do_read(16'h4016);

    // Randomised traffic
    for (int it = 0; it < 30; it++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        logic [7:0] b;
        int sel;
        sel = $urandom_range(0, 9);
        b = (sel < 3) ? 8'hF0 : (sel < 6) ? 8'hF1 : 8'($urandom);
        send_byte(b, ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 3) != 0) strobe_pulse();
      for (int r = $urandom_range(1, 10); r > 0; r--) begin
        case ($urandom_range(0, 9))
          0:       do_read(16'h4016, $urandom_range(2, 4));
          1:       do_write(16'h4017, 8'($urandom));
          2:       do_write_read(8'h00);
          3:       do_read(16'h4000 + 16'($urandom_range(0, 31)));
          default: do_read($urandom_range(0, 1) ? 16'h4017 : 16'h4016);
        endcase
      end
    end

    repeat (5) tick();
    tests++;
    if (exp_ev.size() != 0 || exp_rd.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d pulses and %0d reads unobserved, expected 0 and 0",
               exp_ev.size(), exp_rd.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
